// File: rtl/gpio_cond_pkg.sv
// gpio_cond_pkg: default sizes and legal parameter ranges for the GPIO input conditioner.
package gpio_cond_pkg;
    localparam int DEF_NPINS       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_DEPTH    = 3;
    localparam int DEF_PRESC_W     = 16;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;
    localparam int MIN_DB_DEPTH    = 2;
    localparam int MAX_DB_DEPTH    = 8;
endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: one pin's synchroniser, debounce history, conditioned level and edge pulses.
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_DEPTH    = DEF_DB_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    input  logic en,
    input  logic tick,
    output logic pin,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic [DB_DEPTH-1:0]    hist;
    logic [DB_DEPTH-1:0]    hist_next;
    logic                   s;
    logic                   prev;
    logic                   pin_next;

    assign s = sync[SYNC_STAGES-1];

    // While bypassed the history mirrors the level pin is taking, so enabling debounce never moves pin.
    always_comb begin
        pin_next  = en ? (&hist ? 1'b1 : (~|hist ? 1'b0 : pin)) : s;
        hist_next = !en ? {DB_DEPTH{s}} : (tick ? {hist[DB_DEPTH-2:0], s} : hist);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            hist <= '0;
            pin  <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad};
            hist <= hist_next;
            pin  <= pin_next;
            prev <= pin;
            rise <= pin & ~prev;
            fall <= ~pin & prev;
        end
    end
endmodule

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: per-pin sync/debounce/edge stage for WGPIODIN; GPIO_COND_EDGE_IRQ_EN adds sticky edge IRQs.
module gpio_in_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int NPINS       = DEF_NPINS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_DEPTH    = DEF_DB_DEPTH,
    parameter int PRESC_W     = DEF_PRESC_W
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NPINS-1:0]   pad_in,
    input  logic [NPINS-1:0]   db_en,
    input  logic [PRESC_W-1:0] db_prescale,
    output logic [NPINS-1:0]   pin_out,
    output logic [NPINS-1:0]   rise_evt,
    output logic [NPINS-1:0]   fall_evt,
    input  logic [NPINS-1:0]   irq_rise_en,
    input  logic [NPINS-1:0]   irq_fall_en,
    input  logic [NPINS-1:0]   irq_clr,
    output logic [NPINS-1:0]   irq_status,
    output logic               irq
);
    logic [PRESC_W-1:0] cnt;
    logic               tick;

    // Compare with >= so a prescale lowered below the running count ticks immediately.
    assign tick = cnt >= db_prescale;

    always_ff @(posedge HCLK) begin
        cnt <= (HRESET || tick) ? '0 : cnt + PRESC_W'(1);
    end

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        gpio_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_DEPTH   (DB_DEPTH)
        ) u_bit (
            .clk (HCLK),
            .rst (HRESET),
            .pad (pad_in[i]),
            .en  (db_en[i]),
            .tick(tick),
            .pin (pin_out[i]),
            .rise(rise_evt[i]),
            .fall(fall_evt[i])
        );
    end

`ifdef GPIO_COND_EDGE_IRQ_EN
    logic [NPINS-1:0] status_next;

    // Set terms are OR-ed after the clear, so a fresh edge beats a simultaneous clear.
    assign status_next = (irq_status & ~irq_clr) | (rise_evt & irq_rise_en) | (fall_evt & irq_fall_en);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= status_next;
            irq        <= |status_next;
        end
    end
`else
    logic unused_irq_in;

    assign unused_irq_in = ^{irq_rise_en, irq_fall_en, irq_clr};
    assign irq_status    = '0;
    assign irq           = 1'b0;
`endif
endmodule
